ice_risc_rv_core: RTL and testbench
===================================

# ice_risc_rv_core

Multi-cycle RV32I integer core; the CPU of the ice-risc SoC. It fetches and executes instructions from a single flat memory port (the companion `simple_memory` block) with separate read and write address buses and byte strobes. There is no stall handshake: memory read latency is fixed at one cycle. One instruction takes 2 cycles, or 3 for loads.

## Interface
- No parameters.
- iClk  input  1  clock. All state updates on the rising edge.
- inRst  input  1  reset, asynchronous, active-low. One clock (iClk), asynchronous active-low reset inRst.
- oReadAddr  output  32  byte address of the instruction fetch or load. Memory ignores bits [1:0].
- oWriteAddr  output  32  store address. Bits [1:0] are always 0.
- oWriteData  output  32  store data, already placed in the correct byte lanes.
- oWstrb  output  4  byte write enables. Bit n enables byte n. Non-zero for exactly one cycle per store.
- iReadData  input  32  word at oReadAddr as sampled at the previous rising edge (synchronous read, 1-cycle latency).

## Operation
- State:
  - pc, 32 bits.
  - x1..x31, 32 bits each. x0 always reads 0; writes to x0 are discarded.
  - ir, the latched instruction.
  - FSM: FETCH, EXEC, LOAD, HALT.
- FETCH:
  - oReadAddr = pc.
  - Next state EXEC.
- EXEC: decode iReadData (the instruction) and latch it into ir.
  - OP/OP-IMM (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and immediate forms): write rd, pc += 4.
  - Shift amount is [4:0] of rs2 or of the immediate. SLT is signed; SLTU is unsigned.
  - LUI writes rd = imm<<12. AUIPC writes rd = pc + (imm<<12). Then pc += 4.
  - JAL: rd = pc + 4, pc = pc + J-imm.
  - JALR: rd = pc + 4, pc = (rs1 + I-imm) with bits [1:0] cleared. rs1 is read before rd is written.
  - Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: taken sets pc = pc + B-imm; not taken sets pc += 4.
  - Loads: oReadAddr = rs1 + I-imm; next state LOAD.
  - Stores: ea = rs1 + S-imm. Drive oWriteAddr = {ea[31:2], 2'b00}.
    - SB: byte replicated to all 4 lanes, oWstrb = 1<<ea[1:0].
    - SH: half replicated to both halves, oWstrb = 0011 or 1100 by ea[1].
    - SW: oWstrb = 1111.
    - Then pc += 4.
  - FENCE: NOP, pc += 4.
  - All non-load instructions return to FETCH.
- LOAD: select the data from iReadData using the latched ea[1:0].
  - LB/LBU: byte lane. LH/LHU: lane ea[1]. LW: whole word, ea[1:0] ignored.
  - Sign- or zero-extend, write rd, pc += 4, go to FETCH.
- Idle drive: when not storing, oWstrb, oWriteAddr and oWriteData = 0. In all states except EXEC of a load, oReadAddr = pc.
- Misaligned jump targets are forced to word alignment (bits [1:0] cleared).
- Misaligned halfword/word accesses are not trapped; low address bits are ignored as described above.
- Register file has 2 combinational read ports and 1 write port.

## Timing
- While inRst = 0: pc = 0, state = FETCH, registers = 0, oReadAddr = 0, oWstrb = 0, oWriteAddr = 0, oWriteData = 0.
- Reset assertion takes effect immediately, mid-instruction included: any active oWstrb drops to 0 combinationally.
- After reset release:
  - First rising edge: FETCH of address 0 completes.
  - Second edge: EXEC.
- Throughput: 2 cycles per instruction; loads take 3.
- Register, pc and store effects commit at the edge that ends EXEC (or LOAD).
- A store in EXEC is followed by the next FETCH. If that fetch reads the stored address, it sees the new data.

## Configuration
- ICE_RISC_TRAP_EN defined:
  - ECALL, EBREAK, any SYSTEM opcode and any undefined opcode/funct move the FSM to HALT.
  - In HALT: pc is not updated, oReadAddr holds the trapping pc, oWstrb = 0 forever until reset.
- ICE_RISC_TRAP_EN undefined: all of those instructions execute as NOP (pc += 4) and HALT is unreachable.

## Test plan
- Reset: hold inRst low 3 cycles, then release. oReadAddr = 0x0 and oWstrb = 0 during reset. oReadAddr = 0x4 in the third cycle after release.
- ADDI x1,x0,5 (0x00500093) @0, then SW x1,0x100(x0) (0x10102023) @4: in cycle 4, oWriteAddr = 0x100, oWriteData = 0x5, oWstrb = 1111.
- LUI/ADDI set x1 = 0x12345678. SB x1,0x101(x0) gives oWriteAddr = 0x100, oWriteData = 0x78787878, oWstrb = 0010. SH x1,0x102(x0) gives oWstrb = 1100, data 0x56785678.
- Memory word 0x200 = 0x000080FF:
  - LB x2,0x200(x0) then SW x2 gives stored 0xFFFFFFFF.
  - LBU x3,0x201(x0) gives 0x00000080.
  - LH x4,0x200(x0) gives 0xFFFF80FF.
- JAL x1,+8 at 0x10: x1 = 0x14, next fetch 0x18. BNE x0,x0 does not branch. BEQ x0,x0,-8 loops back (fetch address decreases by 8). ADDI x0,x0,7 leaves x0 = 0.
- With ICE_RISC_TRAP_EN: ECALL (0x00000073) at 0x8 gives oReadAddr stuck at 0x8 and no further stores for 100 cycles. Without the macro, fetch proceeds to 0xC.

Source files
------------

// File: rtl/ice_risc_rv_core.sv
// ---------------------------------------------------------------------------
// ice_risc_rv_core
//   Multi-cycle RV32I integer core for the ice-risc SoC. Instructions are
//   fetched and executed through one flat memory port with a fixed one-cycle
//   synchronous read latency. Non-load instructions take 2 cycles
//   (FETCH, EXEC). Loads take 3 cycles (FETCH, EXEC, LOAD).
//
// Ports
//   iClk        in   1   clock, rising edge
//   inRst       in   1   asynchronous active-low reset
//   oReadAddr   out  32  fetch or load byte address (memory ignores [1:0])
//   oWriteAddr  out  32  word-aligned store address, 0 when not storing
//   oWriteData  out  32  store data already placed in its byte lanes
//   oWstrb      out  4   byte write enables, non-zero only in a store's EXEC
//   iReadData   in   32  word read at oReadAddr on the previous rising edge
//
// Configuration
//   ICE_RISC_TRAP_EN  When this macro is defined, SYSTEM opcodes and
//                     undefined opcodes or functs halt the core. The core
//                     stays halted until reset. When the macro is not
//                     defined, these instructions retire as NOPs.
// ---------------------------------------------------------------------------
module ice_risc_rv_core (
    input  logic        iClk,
    input  logic        inRst,
    output logic [31:0] oReadAddr,
    output logic [31:0] oWriteAddr,
    output logic [31:0] oWriteData,
    output logic [3:0]  oWstrb,
    input  logic [31:0] iReadData
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] r_regs [0:31];
    logic [31:0] r_ir;
    logic [1:0]  r_ea_lo;

    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_ea;
    logic [31:0] w_alu_b;
    logic        w_alu_alt;
    logic [31:0] w_alu_res;
    logic        w_illegal;
    logic        w_rd_we;
    logic [31:0] w_rd_data;
    logic        w_load_en;
    logic        w_store_en;

    // ALU for OP and OP-IMM. alt selects SUB or SRA.
    function automatic logic [31:0] f_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        case (f3)
            3'b000: begin
                if (alt) res = a - b;
                else     res = a + b;
            end
            3'b001: res = a << b[4:0];
            3'b010: res = {31'd0, ($signed(a) < $signed(b))};
            3'b011: res = {31'd0, (a < b)};
            3'b100: res = a ^ b;
            3'b101: begin
                // The shift is kept in its own statement. This keeps the
                // signed operand from being converted to unsigned.
                if (alt) res = $signed(a) >>> b[4:0];
                else     res = a >> b[4:0];
            end
            3'b110: res = a | b;
            3'b111: res = a & b;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Branch condition evaluation.
    function automatic logic f_branch(input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
        logic taken;
        case (f3)
            3'b000: taken = (a == b);
            3'b001: taken = (a != b);
            3'b100: taken = ($signed(a) <  $signed(b));
            3'b101: taken = ($signed(a) >= $signed(b));
            3'b110: taken = (a <  b);
            3'b111: taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Lane selection and sign or zero extension for loads.
    function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = word >> {lo, 3'b000};
        half    = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000: res = {{24{shifted[7]}}, shifted[7:0]};
            3'b100: res = {24'd0, shifted[7:0]};
            3'b001: res = {{16{half[15]}}, half};
            3'b101: res = {16'd0, half};
            3'b010: res = word;
            default: res = word;
        endcase
        return res;
    endfunction

    // In EXEC the instruction arrives on iReadData. In LOAD it comes from
    // the latched copy, so the same decoder serves both states.
    assign w_inst    = (r_state == ST_EXEC) ? iReadData : r_ir;
    assign w_opcode  = w_inst[6:0];
    assign w_rd      = w_inst[11:7];
    assign w_funct3  = w_inst[14:12];
    assign w_rs1     = w_inst[19:15];
    assign w_rs2     = w_inst[24:20];
    assign w_funct7  = w_inst[31:25];
    assign w_imm_i   = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s   = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b   = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                        w_inst[11:8], 1'b0};
    assign w_imm_u   = {w_inst[31:12], 12'd0};
    assign w_imm_j   = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                        w_inst[30:21], 1'b0};

    // r_regs[0] is reset to zero and never written, so x0 always reads zero.
    assign w_rs1_val  = r_regs[w_rs1];
    assign w_rs2_val  = r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_ea       = w_rs1_val + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_alu_b    = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;
    // Only SRAI uses bit 30 among the immediate forms. An ADDI with a large
    // immediate must not turn into a subtract.
    assign w_alu_alt  = (w_opcode == OPC_OP) ? w_funct7[5]
                                             : ((w_funct3 == 3'b101) && w_funct7[5]);
    assign w_alu_res  = f_alu(w_funct3, w_alu_alt, w_rs1_val, w_alu_b);

    // Decode of SYSTEM, undefined opcodes and undefined funct encodings.
    always_comb begin
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_illegal = !((w_funct7 == 7'h00) ||
                              ((w_funct7 == 7'h20) &&
                               ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            OPC_OPIMM: begin
                if (w_funct3 == 3'b001) begin
                    w_illegal = (w_funct7 != 7'h00);
                end else if (w_funct3 == 3'b101) begin
                    w_illegal = !((w_funct7 == 7'h00) || (w_funct7 == 7'h20));
                end else begin
                    w_illegal = 1'b0;
                end
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: w_illegal = 1'b0;
            OPC_JALR:   w_illegal = (w_funct3 != 3'b000);
            OPC_BRANCH: w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            OPC_LOAD:   w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                    (w_funct3 == 3'b111);
            OPC_STORE:  w_illegal = (w_funct3 > 3'b010);
            OPC_SYSTEM: w_illegal = 1'b1;
            default:    w_illegal = 1'b1;
        endcase
    end

    // Next-state, next-pc and register write-back decision.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_rd_we      = 1'b0;
        w_rd_data    = 32'd0;
        w_load_en    = 1'b0;
        w_store_en   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_next_state = ST_FETCH;
                w_next_pc    = w_pc_plus4;
                if (w_illegal) begin
`ifdef ICE_RISC_TRAP_EN
                    w_next_state = ST_HALT;
                    w_next_pc    = r_pc;
`else
                    w_next_state = ST_FETCH;
`endif
                end else begin
                    case (w_opcode)
                        OPC_OP, OPC_OPIMM: begin
                            w_rd_we   = 1'b1;
                            w_rd_data = w_alu_res;
                        end
                        OPC_LUI: begin
                            w_rd_we   = 1'b1;
                            w_rd_data = w_imm_u;
                        end
                        OPC_AUIPC: begin
                            w_rd_we   = 1'b1;
                            w_rd_data = r_pc + w_imm_u;
                        end
                        OPC_JAL: begin
                            w_rd_we   = 1'b1;
                            w_rd_data = w_pc_plus4;
                            w_next_pc = (r_pc + w_imm_j) & ALIGN_MASK;
                        end
                        OPC_JALR: begin
                            w_rd_we   = 1'b1;
                            w_rd_data = w_pc_plus4;
                            w_next_pc = (w_rs1_val + w_imm_i) & ALIGN_MASK;
                        end
                        OPC_BRANCH: begin
                            if (f_branch(w_funct3, w_rs1_val, w_rs2_val)) begin
                                w_next_pc = (r_pc + w_imm_b) & ALIGN_MASK;
                            end else begin
                                w_next_pc = w_pc_plus4;
                            end
                        end
                        OPC_LOAD: begin
                            w_load_en    = 1'b1;
                            w_next_state = ST_LOAD;
                            w_next_pc    = r_pc;
                        end
                        OPC_STORE: begin
                            w_store_en = 1'b1;
                        end
                        default: begin
                            w_rd_we = 1'b0;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                w_next_state = ST_FETCH;
                w_next_pc    = w_pc_plus4;
                w_rd_we      = 1'b1;
                w_rd_data    = f_load_ext(w_funct3, r_ea_lo, iReadData);
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Memory port drive. Store outputs are combinational from r_state, so a
    // reset that forces FETCH drops oWstrb at once.
    always_comb begin
        oReadAddr = w_load_en ? w_ea : r_pc;
        if (w_store_en) begin
            oWriteAddr = {w_ea[31:2], 2'b00};
            case (w_funct3)
                3'b000: begin
                    oWriteData = {4{w_rs2_val[7:0]}};
                    oWstrb     = 4'b0001 << w_ea[1:0];
                end
                3'b001: begin
                    oWriteData = {2{w_rs2_val[15:0]}};
                    oWstrb     = w_ea[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    oWriteData = w_rs2_val;
                    oWstrb     = 4'b1111;
                end
            endcase
        end else begin
            oWriteAddr = 32'd0;
            oWriteData = 32'd0;
            oWstrb     = 4'b0000;
        end
    end

    // FSM state, pc, latched instruction and load lane register.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            r_state <= ST_FETCH;
            r_pc    <= 32'd0;
            r_ir    <= 32'd0;
            r_ea_lo <= 2'b00;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (r_state == ST_EXEC) begin
                r_ir    <= iReadData;
                r_ea_lo <= w_ea[1:0];
            end else begin
                r_ir    <= r_ir;
                r_ea_lo <= r_ea_lo;
            end
        end
    end

    // Register file write port. Writes to x0 are dropped.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            if (w_rd_we && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ice_risc_rv_core.sv
// ---------------------------------------------------------------------------
// tb_ice_risc_rv_core
//   Directed testbench for ice_risc_rv_core. It contains a small synchronous
//   memory with byte strobes and a log of every store the core issues.
//   Expected values were worked out by hand from the RV32I encodings below.
// ---------------------------------------------------------------------------
module tb_ice_risc_rv_core;

    logic        iClk = 1'b0;
    logic        inRst;
    logic [31:0] oReadAddr;
    logic [31:0] oWriteAddr;
    logic [31:0] oWriteData;
    logic [3:0]  oWstrb;
    logic [31:0] r_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] img [0:1023];
    logic        tb_load;

    logic [31:0] st_addr [$];
    logic [31:0] st_data [$];
    logic [3:0]  st_strb [$];

    int n_checks = 0;
    int n_errors = 0;

    ice_risc_rv_core dut (
        .iClk       (iClk),
        .inRst      (inRst),
        .oReadAddr  (oReadAddr),
        .oWriteAddr (oWriteAddr),
        .oWriteData (oWriteData),
        .oWstrb     (oWstrb),
        .iReadData  (r_rdata)
    );

    always #5 iClk = ~iClk;

    // Synchronous memory with a one-cycle read and a byte-strobed write.
    // While tb_load is high, the memory is reloaded from img.
    always @(posedge iClk) begin
        if (tb_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= img[i];
        end else begin
            r_rdata <= mem[oReadAddr[11:2]];
            for (int n = 0; n < 4; n++) begin
                if (oWstrb[n]) mem[oWriteAddr[11:2]][n*8 +: 8] <= oWriteData[n*8 +: 8];
            end
        end
    end

    // Store log, sampled away from the active edge.
    always @(negedge iClk) begin
        if (inRst && (oWstrb != 4'd0)) begin
            st_addr.push_back(oWriteAddr);
            st_data.push_back(oWriteData);
            st_strb.push_back(oWstrb);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 32'd0;
    endtask

    task automatic next_cycle();
        @(negedge iClk);
        #1;
    endtask

    logic [31:0] exp_addr [0:9];
    logic [31:0] exp_data [0:9];
    logic [3:0]  exp_strb [0:9];

    initial begin
        inRst   = 1'b0;
        tb_load = 1'b1;
        r_rdata = 32'd0;

        // Program 1: ALU, stores, loads, jumps, branches, x0.
        clear_img();
        img[0]  = 32'h00500093; // 00 addi x1,x0,5
        img[1]  = 32'h10102023; // 04 sw   x1,0x100(x0)
        img[2]  = 32'h123450B7; // 08 lui  x1,0x12345
        img[3]  = 32'h67808093; // 0C addi x1,x1,0x678
        img[4]  = 32'h101000A3; // 10 sb   x1,0x101(x0)
        img[5]  = 32'h10101123; // 14 sh   x1,0x102(x0)
        img[6]  = 32'h20000103; // 18 lb   x2,0x200(x0)
        img[7]  = 32'h10202223; // 1C sw   x2,0x104(x0)
        img[8]  = 32'h20104183; // 20 lbu  x3,0x201(x0)
        img[9]  = 32'h10302423; // 24 sw   x3,0x108(x0)
        img[10] = 32'h20001203; // 28 lh   x4,0x200(x0)
        img[11] = 32'h10402623; // 2C sw   x4,0x10C(x0)
        img[12] = 32'h008000EF; // 30 jal  x1,+8
        img[13] = 32'h1E002823; // 34 sw   x0,0x1F0(x0)  (must be skipped)
        img[14] = 32'h10102823; // 38 sw   x1,0x110(x0)
        img[15] = 32'h00001463; // 3C bne  x0,x0,+8      (not taken)
        img[16] = 32'h00700013; // 40 addi x0,x0,7
        img[17] = 32'h10002A23; // 44 sw   x0,0x114(x0)
        img[18] = 32'h00128293; // 48 addi x5,x5,1
        img[19] = 32'h10502C23; // 4C sw   x5,0x118(x0)
        img[20] = 32'hFE000CE3; // 50 beq  x0,x0,-8
        img[128] = 32'h000080FF; // data at 0x200

        exp_addr[0] = 32'h100; exp_data[0] = 32'h00000005; exp_strb[0] = 4'b1111;
        exp_addr[1] = 32'h100; exp_data[1] = 32'h78787878; exp_strb[1] = 4'b0010;
        exp_addr[2] = 32'h100; exp_data[2] = 32'h56785678; exp_strb[2] = 4'b1100;
        exp_addr[3] = 32'h104; exp_data[3] = 32'hFFFFFFFF; exp_strb[3] = 4'b1111;
        exp_addr[4] = 32'h108; exp_data[4] = 32'h00000080; exp_strb[4] = 4'b1111;
        exp_addr[5] = 32'h10C; exp_data[5] = 32'hFFFF80FF; exp_strb[5] = 4'b1111;
        exp_addr[6] = 32'h110; exp_data[6] = 32'h00000034; exp_strb[6] = 4'b1111;
        exp_addr[7] = 32'h114; exp_data[7] = 32'h00000000; exp_strb[7] = 4'b1111;
        exp_addr[8] = 32'h118; exp_data[8] = 32'h00000001; exp_strb[8] = 4'b1111;
        exp_addr[9] = 32'h118; exp_data[9] = 32'h00000002; exp_strb[9] = 4'b1111;

        repeat (3) @(posedge iClk);
        tb_load = 1'b0;
        next_cycle();
        check_eq("rst_raddr", oReadAddr, 32'h0);
        check_eq("rst_wstrb", {28'd0, oWstrb}, 32'h0);
        check_eq("rst_waddr", oWriteAddr, 32'h0);
        check_eq("rst_wdata", oWriteData, 32'h0);

        // Release the reset on a falling edge. The current half-cycle is cycle 1.
        inRst = 1'b1;
        #1;
        check_eq("c1_raddr", oReadAddr, 32'h0);
        next_cycle();
        next_cycle();
        check_eq("c3_raddr", oReadAddr, 32'h4);
        next_cycle();
        check_eq("c4_waddr", oWriteAddr, 32'h100);
        check_eq("c4_wdata", oWriteData, 32'h5);
        check_eq("c4_wstrb", {28'd0, oWstrb}, 32'hF);

        repeat (70) @(negedge iClk);
        #1;
        check_eq("nstores_ge10", {31'd0, (st_addr.size() >= 10)}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i < st_addr.size()) begin
                check_eq($sformatf("st%0d_addr", i), st_addr[i], exp_addr[i]);
                check_eq($sformatf("st%0d_data", i), st_data[i], exp_data[i]);
                check_eq($sformatf("st%0d_strb", i), {28'd0, st_strb[i]}, {28'd0, exp_strb[i]});
            end
        end
        check_eq("mem_100", mem[64], 32'h56787805);

        // Program 2: an asynchronous reset in the middle of a store, then ECALL.
        @(negedge iClk);
        inRst = 1'b0;
        clear_img();
        img[0] = 32'h00500093; // 00 addi x1,x0,5
        img[1] = 32'h10102023; // 04 sw   x1,0x100(x0)
        img[2] = 32'h00000073; // 08 ecall
        img[3] = 32'h12102023; // 0C sw   x1,0x120(x0)
        img[4] = 32'h0000006F; // 10 jal  x0,0
        tb_load = 1'b1;
        repeat (2) @(posedge iClk);
        tb_load = 1'b0;
        @(negedge iClk);
        inRst = 1'b1;
        #1;
        next_cycle();
        next_cycle();
        next_cycle();
        check_eq("mid_wstrb_pre", {28'd0, oWstrb}, 32'hF);
        #2;
        inRst = 1'b0;
        #1;
        check_eq("mid_wstrb_rst", {28'd0, oWstrb}, 32'h0);
        check_eq("mid_raddr_rst", oReadAddr, 32'h0);

        @(negedge iClk);
        st_addr.delete();
        st_data.delete();
        st_strb.delete();
        inRst = 1'b1;
        #1;
        for (int c = 2; c <= 7; c++) next_cycle();
`ifdef ICE_RISC_TRAP_EN
        check_eq("trap_c7_raddr", oReadAddr, 32'h8);
`else
        check_eq("nop_c7_raddr", oReadAddr, 32'hC);
`endif
        repeat (100) @(negedge iClk);
        #1;
`ifdef ICE_RISC_TRAP_EN
        check_eq("trap_raddr_end", oReadAddr, 32'h8);
        check_eq("trap_nstores", st_addr.size(), 32'd1);
`else
        check_eq("nop_raddr_end", oReadAddr, 32'h10);
        check_eq("nop_nstores", st_addr.size(), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
